// File: rtl/demux_pkg.sv
// demux_pkg: shared FSM state type and route constants for the 1:2 stream demux
package demux_pkg;
    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;
    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;
endpackage

// File: rtl/demux_1x2_stream_if.sv
// demux_1x2_stream_if: valid/ready beat stream with data and end-of-packet marker
interface demux_1x2_stream_if #(parameter int WIDTH = 2);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             last;
    logic             ready;
    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/demux_out_reg.sv
// demux_out_reg: 1-entry output register; refill is allowed in the same cycle as a drain
module demux_out_reg #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             wr_last_i,
    output logic             free_o,
    output logic             drain_o,
    demux_1x2_stream_if.master m
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    assign free_o  = !valid_q | m.ready;
    assign drain_o = valid_q & m.ready;
    assign m.valid = valid_q;
    assign m.data  = data_q;
    assign m.last  = last_q;

    // a write always wins; otherwise an undrained beat stays put, so data/last hold while stalled
    always_comb begin
        valid_d = wr_en_i | (valid_q & !m.ready);
        data_d  = wr_en_i ? wr_data_i : data_q;
        last_d  = wr_en_i ? wr_last_i : last_q;
    end

    // register the slot; reset discards any held beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: rtl/demux_1x2_stream.sv
// demux_1x2_stream: steers whole packets from one stream to out0/out1, route locked per packet
module demux_1x2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_1x2_stream_if.slave  in_s,
    input  logic               select,
    demux_1x2_stream_if.master out0,
    demux_1x2_stream_if.master out1,
    output logic [CNT_W-1:0]   pkt_cnt0,
    output logic [CNT_W-1:0]   pkt_cnt1,
    output logic               busy
);
    state_e           state_q;
    logic             route_q, busy_q;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             route, accept;
    logic             free0, free1, drain0, drain1;

    assign route     = (state_q == ST_IDLE) ? select : route_q;
    assign in_s.ready = (route == SEL_OUT1) ? free1 : free0;
    assign accept    = in_s.valid & in_s.ready;
    assign busy      = busy_q;
    assign pkt_cnt0  = cnt0_q;
    assign pkt_cnt1  = cnt1_q;

    demux_out_reg #(.WIDTH(WIDTH)) u_out0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(accept & (route == SEL_OUT0)), .wr_data_i(in_s.data), .wr_last_i(in_s.last),
        .free_o(free0), .drain_o(drain0), .m(out0)
    );

    demux_out_reg #(.WIDTH(WIDTH)) u_out1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(accept & (route == SEL_OUT1)), .wr_data_i(in_s.data), .wr_last_i(in_s.last),
        .free_o(free1), .drain_o(drain1), .m(out1)
    );

    // packet FSM: every accepted beat re-latches the route; a non-last beat locks it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            route_q <= SEL_OUT0;
            busy_q  <= 1'b0;
        end else if (accept) begin
            route_q <= route;
            state_q <= in_s.last ? ST_IDLE : ST_LOCKED;
            busy_q  <= !in_s.last;
        end
    end

    // a packet counts as completed when its last beat leaves the output register
    always_comb begin
        cnt0_d = cnt0_q + CNT_W'(drain0 & out0.last);
        cnt1_d = cnt1_q + CNT_W'(drain1 & out1.last);
    end

    // wrapping completed-packet counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
endmodule
